// File: rtl/cobs_arb_pkg.sv
// Shared types and constants for the COBS stream arbiter.
package cobs_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        DRAIN
    } state_t;

    localparam logic [7:0] HEADER_TAG = 8'h80;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin requester pick: the first active request after the last grant wins.
module rr_priority_select
    import cobs_arb_pkg::*;
#(
    parameter  int N    = 4,
    localparam int CH_W = ch_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [CH_W-1:0] last,
    output logic            any,
    output logic [CH_W-1:0] sel
);

    // Scan channels last+1, last+2, ... modulo N and keep the first requester.
    always_comb begin
        any = 1'b0;
        sel = last;
        for (int i = 1; i <= N; i++) begin
            if (!any && req[(int'(last) + i) % N]) begin
                any = 1'b1;
                sel = CH_W'((int'(last) + i) % N);
            end
        end
    end

endmodule

// File: rtl/cobs_stream_arbiter.sv
// Packet-granular round-robin arbiter that funnels several raw byte streams
// into one COBS encoder input, with an optional channel tag and a length cap.
module cobs_stream_arbiter
    import cobs_arb_pkg::*;
#(
    parameter  int NUM_CHANNELS = 4,
    parameter  int MAX_PAYLOAD  = 32,
    parameter  int HEADER_EN    = 1,
    localparam int CH_W         = ch_w(NUM_CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CHANNELS*8-1:0] s_tdata,
    input  logic [NUM_CHANNELS-1:0]   s_tvalid,
    input  logic [NUM_CHANNELS-1:0]   s_tlast,
    output logic [NUM_CHANNELS-1:0]   s_tready,
    output logic [7:0]                m_tdata,
    output logic                      m_tvalid,
    output logic                      m_tlast,
    input  logic                      m_tready,
    output logic [CH_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      truncated
);

    localparam int              CNT_W      = $clog2(MAX_PAYLOAD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_PAYLOAD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_PAYLOAD);
    localparam logic [CH_W-1:0]  GRANT_INIT = CH_W'(NUM_CHANNELS - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             req_any;
    logic [CH_W-1:0]  req_sel;
    logic [7:0]       g_data;
    logic             g_valid;
    logic             g_last;
    logic             at_limit;
    logic             beat_fire;

    assign g_data    = s_tdata[int'(grant_id)*8 +: 8];
    assign g_valid   = s_tvalid[grant_id];
    assign g_last    = s_tlast[grant_id];
    assign at_limit  = (count == CNT_LAST);
    assign beat_fire = g_valid && m_tready;
    assign busy      = (state != IDLE);

    rr_priority_select #(
        .N(NUM_CHANNELS)
    ) u_select (
        .req (s_tvalid),
        .last(grant_id),
        .any (req_any),
        .sel (req_sel)
    );

    // Packet-level FSM: grant in IDLE, optional tag, pass payload, then discard any overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_id  <= GRANT_INIT;
            count     <= '0;
            truncated <= 1'b0;
        end else begin
            truncated <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        grant_id <= req_sel;
                        count    <= '0;
                        state    <= (HEADER_EN != 0) ? HEADER : PAYLOAD;
                    end
                end
                HEADER: begin
                    if (m_tready) begin
                        state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (beat_fire) begin
                        if (count != CNT_MAX) begin
                            count <= count + CNT_W'(1);
                        end
                        if (g_last) begin
                            state <= IDLE;
                        end else if (at_limit) begin
                            truncated <= 1'b1;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (g_valid && g_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output steering: tag from registered grant, payload passes straight through.
    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tlast  = 1'b0;
        s_tready = '0;
        case (state)
            HEADER: begin
                m_tvalid = 1'b1;
                m_tdata  = HEADER_TAG | 8'(grant_id);
            end
            PAYLOAD: begin
                m_tvalid = g_valid;
                m_tdata  = g_data;
                m_tlast  = g_last | at_limit;
                s_tready = NUM_CHANNELS'(m_tready) << grant_id;
            end
            DRAIN: begin
                s_tready = NUM_CHANNELS'(1) << grant_id;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cobs_stream_arbiter.sv
// Self-checking bench for cobs_stream_arbiter: a packet-level model predicts
// every output per cycle, and directed scenarios pin the model with literals.
module tb_cobs_stream_arbiter;

    localparam int NUM_CH = 4;
    localparam int MAX_PL = 32;
    localparam int HDR_EN = 1;
    localparam int CH_W   = 2;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       hdr;
        logic       trunc_end;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_CH*8-1:0]   s_tdata;
    logic [NUM_CH-1:0]     s_tvalid;
    logic [NUM_CH-1:0]     s_tlast;
    logic [NUM_CH-1:0]     s_tready;
    logic [7:0]            m_tdata;
    logic                  m_tvalid;
    logic                  m_tlast;
    logic                  m_tready;
    logic [CH_W-1:0]       grant_id;
    logic                  busy;
    logic                  truncated;

    // Source packets per channel: bit 8 marks the last byte of a packet.
    logic [8:0] src_q [NUM_CH][$];
    logic [7:0] pkt_buf [$];
    exp_t       exp_q [$];
    logic [8:0] out_log [$];

    int checks = 0;
    int failures = 0;
    int valid_pct = 100;
    int ready_mode = 0;
    int trunc_seen = 0;
    int trunc_before;

    logic            mdl_busy = 1'b0;
    logic [CH_W-1:0] mdl_grant = CH_W'(NUM_CH - 1);
    logic            exp_trunc = 1'b0;

    cobs_stream_arbiter #(
        .NUM_CHANNELS(NUM_CH),
        .MAX_PAYLOAD (MAX_PL),
        .HEADER_EN   (HDR_EN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tready (m_tready),
        .grant_id (grant_id),
        .busy     (busy),
        .truncated(truncated)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive every source from its packet queue plus the downstream ready pattern.
    task automatic applyStimulus();
        for (int k = 0; k < NUM_CH; k++) begin
            if (src_q[k].size() > 0 && $urandom_range(99) < valid_pct) begin
                s_tvalid[k]        = 1'b1;
                s_tdata[8*k +: 8]  = src_q[k][0][7:0];
                s_tlast[k]         = src_q[k][0][8];
            end else begin
                s_tvalid[k]        = 1'b0;
                s_tdata[8*k +: 8]  = 8'h00;
                s_tlast[k]         = 1'b0;
            end
        end
        case (ready_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ($urandom_range(99) < 70);
            default: m_tready = ~m_tready;
        endcase
    endtask

    task automatic loadPacket(input int ch);
        for (int i = 0; i < pkt_buf.size(); i++) begin
            src_q[ch].push_back({(i == pkt_buf.size() - 1), pkt_buf[i]});
        end
    endtask

    function automatic int pendingBytes();
        int n = 0;
        for (int k = 0; k < NUM_CH; k++) n += src_q[k].size();
        return n;
    endfunction

    function automatic logic [8:0] logAt(input int i);
        return (i < out_log.size()) ? out_log[i] : 9'h1FF;
    endfunction

    // What the encoder must see for one granted packet: tag, then at most MAX_PL bytes.
    task automatic buildExpected(input int c);
        int len = 0;
        int n;
        for (int i = 0; i < src_q[c].size(); i++) begin
            if (len == 0 && src_q[c][i][8]) len = i + 1;
        end
        if (len == 0) len = src_q[c].size();
        n = (len < MAX_PL) ? len : MAX_PL;
        if (HDR_EN != 0) exp_q.push_back('{data: 8'h80 | 8'(c), last: 1'b0, hdr: 1'b1, trunc_end: 1'b0});
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{data: src_q[c][i][7:0], last: (i == n - 1), hdr: 1'b0,
                              trunc_end: ((i == n - 1) && (len > MAX_PL))});
        end
    endtask

    // One cycle of compare against the model, then advance the model past the next edge.
    task automatic monitorCycle();
        logic              exp_valid = 1'b0;
        logic [7:0]        exp_data = 8'h00;
        logic              exp_last = 1'b0;
        logic [NUM_CH-1:0] exp_ready = '0;
        logic              end_pkt = 1'b0;
        logic              trunc_next = 1'b0;
        int                g = int'(mdl_grant);
        int                pick = -1;

        if (mdl_busy) begin
            if (exp_q.size() > 0) begin
                if (exp_q[0].hdr) begin
                    exp_valid = 1'b1;
                    exp_data  = exp_q[0].data;
                end else begin
                    exp_valid    = s_tvalid[g];
                    exp_ready[g] = m_tready;
                    exp_data     = exp_q[0].data;
                    exp_last     = exp_q[0].last;
                end
            end else begin
                exp_ready[g] = 1'b1;
            end
        end

        checkOutput("m_tvalid", 32'(m_tvalid), 32'(exp_valid));
        if (exp_valid) begin
            checkOutput("m_tdata", 32'(m_tdata), 32'(exp_data));
            checkOutput("m_tlast", 32'(m_tlast), 32'(exp_last));
        end
        checkOutput("s_tready", 32'(s_tready), 32'(exp_ready));
        checkOutput("busy", 32'(busy), 32'(mdl_busy));
        checkOutput("grant_id", 32'(grant_id), 32'(mdl_grant));
        checkOutput("truncated", 32'(truncated), 32'(exp_trunc));
        if (truncated) trunc_seen++;

        if (m_tvalid && m_tready) begin
            out_log.push_back({m_tlast, m_tdata});
            if (exp_q.size() > 0) begin
                trunc_next = exp_q[0].trunc_end;
                void'(exp_q.pop_front());
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (s_tvalid[k] && s_tready[k] && src_q[k].size() > 0) begin
                if (mdl_busy && k == g && src_q[k][0][8]) end_pkt = 1'b1;
                void'(src_q[k].pop_front());
            end
        end
        if (!mdl_busy) begin
            for (int i = 1; i <= NUM_CH; i++) begin
                if (pick < 0 && s_tvalid[(g + i) % NUM_CH]) pick = (g + i) % NUM_CH;
            end
            if (pick >= 0) begin
                mdl_grant = CH_W'(pick);
                mdl_busy  = 1'b1;
                buildExpected(pick);
            end
        end else if (end_pkt) begin
            mdl_busy = 1'b0;
        end
        exp_trunc = trunc_next;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        while (n < budget && (mdl_busy || pendingBytes() > 0)) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput({name, "_done"}, 32'(mdl_busy || pendingBytes() > 0), 32'd0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    // Driver: inputs change 1 time unit after each rising edge.
    initial begin
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            applyStimulus();
        end
    end

    // Monitor: compares on the falling edge, model resets along with the DUT.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                mdl_busy  = 1'b0;
                mdl_grant = CH_W'(NUM_CH - 1);
                exp_trunc = 1'b0;
            end else begin
                monitorCycle();
            end
        end
    end

    // Watchdog so a stuck DUT still ends with a summary.
    initial begin
        #1000000;
        failures++;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        // Reset values while rst_n is held low.
        #12;
        checkOutput("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        checkOutput("rst_m_tdata", 32'(m_tdata), 32'd0);
        checkOutput("rst_m_tlast", 32'(m_tlast), 32'd0);
        checkOutput("rst_s_tready", 32'(s_tready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_grant_id", 32'(grant_id), 32'd3);
        checkOutput("rst_truncated", 32'(truncated), 32'd0);

        // Ch0 and ch2 both pending at reset release, two rounds each.
        pkt_buf = '{8'h11}; loadPacket(0);
        pkt_buf = '{8'h33}; loadPacket(0);
        pkt_buf = '{8'h22}; loadPacket(2);
        pkt_buf = '{8'h44}; loadPacket(2);
        @(posedge clk);
        #3 rst_n = 1'b1;
        waitIdle("rr", 200);
        checkOutput("rr_len", 32'(out_log.size()), 32'd8);
        checkOutput("rr_0", 32'(logAt(0)), 32'h080);
        checkOutput("rr_1", 32'(logAt(1)), 32'h111);
        checkOutput("rr_2", 32'(logAt(2)), 32'h082);
        checkOutput("rr_3", 32'(logAt(3)), 32'h122);
        checkOutput("rr_4", 32'(logAt(4)), 32'h080);
        checkOutput("rr_5", 32'(logAt(5)), 32'h133);
        checkOutput("rr_6", 32'(logAt(6)), 32'h082);
        checkOutput("rr_7", 32'(logAt(7)), 32'h144);

        // Ch0 only, 0x69 0x70.
        out_log.delete();
        pkt_buf = '{8'h69, 8'h70}; loadPacket(0);
        waitIdle("basic", 200);
        checkOutput("basic_len", 32'(out_log.size()), 32'd3);
        checkOutput("basic_0", 32'(logAt(0)), 32'h080);
        checkOutput("basic_1", 32'(logAt(1)), 32'h069);
        checkOutput("basic_2", 32'(logAt(2)), 32'h170);

        // Ready toggling every cycle on a 3-byte ch1 packet.
        out_log.delete();
        ready_mode = 2;
        pkt_buf = '{8'hA1, 8'hA2, 8'hA3}; loadPacket(1);
        waitIdle("toggle", 200);
        checkOutput("toggle_len", 32'(out_log.size()), 32'd4);
        checkOutput("toggle_0", 32'(logAt(0)), 32'h081);
        checkOutput("toggle_1", 32'(logAt(1)), 32'h0A1);
        checkOutput("toggle_2", 32'(logAt(2)), 32'h0A2);
        checkOutput("toggle_3", 32'(logAt(3)), 32'h1A3);
        ready_mode = 0;

        // Ch3 sends 40 beats: cut after 32, one truncation pulse.
        out_log.delete();
        trunc_before = trunc_seen;
        pkt_buf.delete();
        for (int i = 0; i < 40; i++) pkt_buf.push_back(8'(i + 1));
        loadPacket(3);
        waitIdle("trunc", 400);
        checkOutput("trunc_len", 32'(out_log.size()), 32'd33);
        checkOutput("trunc_hdr", 32'(logAt(0)), 32'h083);
        checkOutput("trunc_first", 32'(logAt(1)), 32'h001);
        checkOutput("trunc_lastbeat", 32'(logAt(32)), 32'h120);
        checkOutput("trunc_pulses", 32'(trunc_seen - trunc_before), 32'd1);

        // Exactly 32 beats with tlast on the 32nd: no truncation.
        out_log.delete();
        trunc_before = trunc_seen;
        pkt_buf.delete();
        for (int i = 0; i < 32; i++) pkt_buf.push_back(8'(8'h40 + i));
        loadPacket(2);
        waitIdle("exact", 400);
        checkOutput("exact_len", 32'(out_log.size()), 32'd33);
        checkOutput("exact_lastbeat", 32'(logAt(32)), 32'h15F);
        checkOutput("exact_pulses", 32'(trunc_seen - trunc_before), 32'd0);

        // Random packets on all channels with valid gaps and random ready.
        valid_pct  = 75;
        ready_mode = 1;
        for (int p = 0; p < 60; p++) begin
            int ch  = int'($urandom_range(NUM_CH - 1));
            int len = int'($urandom_range(40, 1));
            pkt_buf.delete();
            for (int i = 0; i < len; i++) pkt_buf.push_back(8'($urandom));
            loadPacket(ch);
        end
        waitIdle("random", 30000);
        valid_pct  = 100;
        ready_mode = 0;

        // Reset mid-payload on ch1, then ch0 must win the next grant.
        out_log.delete();
        pkt_buf.delete();
        for (int i = 0; i < 10; i++) pkt_buf.push_back(8'(8'hC0 + i));
        loadPacket(1);
        begin
            int n = 0;
            while (n < 100 && out_log.size() < 3) begin
                @(posedge clk);
                #2;
                n++;
            end
            checkOutput("midrst_reached", 32'(out_log.size() >= 3), 32'd1);
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
        checkOutput("midrst_m_tdata", 32'(m_tdata), 32'd0);
        checkOutput("midrst_m_tlast", 32'(m_tlast), 32'd0);
        checkOutput("midrst_s_tready", 32'(s_tready), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_grant_id", 32'(grant_id), 32'd3);
        for (int k = 0; k < NUM_CH; k++) src_q[k].delete();
        pkt_buf = '{8'h5A}; loadPacket(0);
        pkt_buf = '{8'h66}; loadPacket(1);
        @(posedge clk);
        #3;
        out_log.delete();
        rst_n = 1'b1;
        waitIdle("midrst", 200);
        checkOutput("midrst_len", 32'(out_log.size()), 32'd4);
        checkOutput("midrst_0", 32'(logAt(0)), 32'h080);
        checkOutput("midrst_1", 32'(logAt(1)), 32'h15A);
        checkOutput("midrst_2", 32'(logAt(2)), 32'h081);
        checkOutput("midrst_3", 32'(logAt(3)), 32'h166);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
